// File: rtl/jc_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : jc_pkg
//  Description : Shared types and helpers for the Johnson-counter sequencer.
//                Holds the sequencer state enum, the command opcodes and the
//                Johnson-code legality test used by the optional checker.
//  Revision    : 1.0  initial release
// ============================================================================
package jc_pkg;

  // Widest counter the legality helper can examine.
  localparam int JC_MAX_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } jc_state_e;

  localparam logic JC_OP_STEP = 1'b0;
  localparam logic JC_OP_LOAD = 1'b1;

  // Every Johnson code is a single run of ones against a run of zeros, so
  // at most one adjacent bit pair (within the low 'width' bits) may differ.
  function automatic logic jc_is_legal(input logic [JC_MAX_W-1:0] code,
                                       input int                  width);
    int diffs;
    diffs = 0;
    for (int i = 0; i < JC_MAX_W - 1; i++) begin
      if ((i + 1 < width) && (code[i] != code[i+1])) begin
        diffs++;
      end
    end
    return (diffs <= 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jc_legal_check.sv
`default_nettype none
// ============================================================================
//  Module      : jc_legal_check
//  Description : Purely combinational Johnson-code legality check.
//  Ports       : jc_count [WIDTH] - code to examine
//                legal    [1]     - 1 when jc_count is a valid Johnson code
//  Revision    : 1.0  initial release
// ============================================================================
module jc_legal_check
  import jc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] jc_count,
  output logic             legal
);

  logic [JC_MAX_W-1:0] w_code;

  // Zero-extension is harmless: the helper only looks at the low WIDTH bits.
  assign w_code = {{(JC_MAX_W - WIDTH){1'b0}}, jc_count};
  assign legal  = jc_is_legal(w_code, WIDTH);

endmodule
`default_nettype wire

// File: rtl/johnson_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : johnson_seq_ctrl
//  Description : Command-driven sequencer for a WIDTH-bit Johnson counter.
//                Accepts LOAD/STEP commands on a valid/ready handshake, drives
//                the counter enable/load pins and pulses done once the counter
//                output reflects the completed command.
//  Config      : JC_LEGAL_CHECK_EN - compiles in the legality checker (illegal
//                LOAD values are suppressed, illegal counts terminate a run,
//                both set the sticky err flag). Undefined: err is tied 0.
//  Ports       : clk, rst_n (async, active-low)
//                cmd_valid/cmd_ready/cmd_op/cmd_steps/cmd_value - command in
//                abort        - early termination request for STEP
//                jc_count     - counter output
//                jc_enable/jc_load_en/jc_load_val - counter controls (regs)
//                busy, done, aborted, steps_left, err - status
//  Revision    : 1.0  initial release
// ============================================================================
module johnson_seq_ctrl
  import jc_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [WIDTH-1:0]  cmd_value,
  input  logic              abort,
  input  logic [WIDTH-1:0]  jc_count,
  output logic              jc_enable,
  output logic              jc_load_en,
  output logic [WIDTH-1:0]  jc_load_val,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] steps_left,
  output logic              err
);

  jc_state_e         r_state;
  logic              r_cmd_ready;
  logic              r_jc_enable;
  logic              r_jc_load_en;
  logic [WIDTH-1:0]  r_jc_load_val;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;
  logic              r_abort_flag;
  logic [STEP_W-1:0] r_steps_left;
  logic              r_err;

  logic w_accept;
  logic w_count_legal;
  logic w_value_legal;

`ifdef JC_LEGAL_CHECK_EN
  jc_legal_check #(.WIDTH(WIDTH)) u_chk_count (
    .jc_count (jc_count),
    .legal    (w_count_legal)
  );

  jc_legal_check #(.WIDTH(WIDTH)) u_chk_value (
    .jc_count (cmd_value),
    .legal    (w_value_legal)
  );

  assign err = r_err;
`else
  logic w_unused_count;

  assign w_count_legal  = 1'b1;
  assign w_value_legal  = 1'b1;
  assign w_unused_count = ^{jc_count, r_err};
  assign err            = 1'b0;
`endif

  assign w_accept = cmd_valid && r_cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b0;
      r_jc_enable   <= 1'b0;
      r_jc_load_en  <= 1'b0;
      r_jc_load_val <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
      r_abort_flag  <= 1'b0;
      r_steps_left  <= '0;
      r_err         <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Ready rises on the first clock after reset release and stays up.
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_cmd_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_err        <= 1'b0;
            r_abort_flag <= 1'b0;
            if (cmd_op == JC_OP_LOAD) begin
              r_state       <= ST_LOAD;
              r_steps_left  <= '0;
              r_jc_load_val <= cmd_value;
              if (w_value_legal) begin
                r_jc_enable  <= 1'b1;
                r_jc_load_en <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end else if (cmd_steps != '0) begin
              r_state      <= ST_RUN;
              r_steps_left <= cmd_steps;
              r_jc_enable  <= 1'b1;
            end else begin
              // Zero-length STEP has nothing to settle.
              r_state      <= ST_DONE;
              r_steps_left <= '0;
              r_done       <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          r_jc_enable  <= 1'b0;
          r_jc_load_en <= 1'b0;
          r_state      <= ST_SETTLE;
        end

        ST_RUN: begin
          if (abort || !w_count_legal) begin
            // Early exit: steps_left keeps the value seen in this cycle.
            r_jc_enable  <= 1'b0;
            r_abort_flag <= 1'b1;
            r_state      <= ST_SETTLE;
            if (!w_count_legal) begin
              r_err <= 1'b1;
            end
          end else begin
            r_steps_left <= r_steps_left - STEP_W'(1);
            if (r_steps_left == STEP_W'(1)) begin
              r_jc_enable <= 1'b0;
              r_state     <= ST_SETTLE;
            end
          end
        end

        ST_SETTLE: begin
          if (!w_count_legal) begin
            r_err <= 1'b1;
          end
          r_state   <= ST_DONE;
          r_done    <= 1'b1;
          r_aborted <= r_abort_flag;
        end

        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_jc_enable <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign jc_enable   = r_jc_enable;
  assign jc_load_en  = r_jc_load_en;
  assign jc_load_val = r_jc_load_val;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign steps_left  = r_steps_left;

endmodule
`default_nettype wire
